// File: rtl/aegis_fw_pkg.sv
// Shared types and default constants for the checker arbiter slice.
package aegis_fw_pkg;
  localparam int CHK_DATA_W       = 32;
  localparam int DEF_STRIKE_LIMIT = 3;
  localparam int DEF_QUAR_CYCLES  = 64;

  typedef enum logic {
    ST_ACTIVE     = 1'b0,
    ST_QUARANTINE = 1'b1
  } port_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first unmasked requester at or after ptr_i.
// Zero latency; a masked or idle port is skipped, and no grant is raised when nothing is eligible.
module rr_arbiter
  import aegis_fw_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  logic [PW:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (!gnt_vld_o && req_i[cand[PW-1:0]] && !mask_i[cand[PW-1:0]]) begin
        gnt_vld_o              = 1'b1;
        gnt_idx_o              = cand[PW-1:0];
        gnt_o[cand[PW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/checker_arbiter.sv
// Shares one pattern checker across NUM_PORTS streams (1-cycle issue latency) and quarantines ports
// that collect STRIKE_LIMIT violations; AEGIS_STICKY_QUARANTINE_EN makes quarantine clear-only.
module checker_arbiter
  import aegis_fw_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int CHK_LATENCY  = 2,
  parameter int STRIKE_LIMIT = DEF_STRIKE_LIMIT,
  parameter int QUAR_CYCLES  = DEF_QUAR_CYCLES,
  localparam int PW = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [CHK_DATA_W*NUM_PORTS-1:0] req_data,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic                            chk_valid,
  output logic [CHK_DATA_W-1:0]           chk_data,
  output logic [PW-1:0]                   chk_port,
  input  logic                            chk_violation,
`ifdef AEGIS_STICKY_QUARANTINE_EN
  input  logic [NUM_PORTS-1:0]            clr_quarantine,
`endif
  output logic [NUM_PORTS-1:0]            quarantine,
  output logic                            alert,
  output logic [PW-1:0]                   alert_port
);

  localparam int SW = $clog2(STRIKE_LIMIT+1);
  localparam logic [SW-1:0] STRIKE_LAST = SW'(STRIKE_LIMIT-1);
`ifndef AEGIS_STICKY_QUARANTINE_EN
  localparam int TW = $clog2(QUAR_CYCLES+1);
`endif

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         gnt_idx;
  logic                  gnt_vld;
  logic [CHK_DATA_W-1:0] win_data;
  port_state_e           state_q   [NUM_PORTS];
  logic [SW-1:0]         strikes_q [NUM_PORTS];
`ifndef AEGIS_STICKY_QUARANTINE_EN
  logic [TW-1:0]         timer_q   [NUM_PORTS];
`endif
  logic                  tag_vld_q  [CHK_LATENCY];
  logic [PW-1:0]         tag_port_q [CHK_LATENCY];
  logic                  viol_hit;
  logic [PW-1:0]         viol_port;

  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) quarantine[k] = (state_q[k] == ST_QUARANTINE);
  end

  rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_rr (
    .req_i     (req_valid),
    .mask_i    (quarantine),
    .ptr_i     (ptr_q),
    .gnt_o     (req_ready),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (req_ready[k]) win_data = req_data[CHK_DATA_W*k +: CHK_DATA_W];
    end
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == PW'(NUM_PORTS-1)) ? '0 : gnt_idx + PW'(1);
  end

  // Tag line mirrors the checker pipeline so each verdict lines up with the word that caused it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      chk_valid <= 1'b0;
      chk_data  <= '0;
      chk_port  <= '0;
      for (int s = 0; s < CHK_LATENCY; s++) begin
        tag_vld_q[s]  <= 1'b0;
        tag_port_q[s] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      chk_valid <= gnt_vld;
      if (gnt_vld) begin
        chk_data <= win_data;
        chk_port <= gnt_idx;
      end
      tag_vld_q[0]  <= chk_valid;
      tag_port_q[0] <= chk_port;
      for (int s = 1; s < CHK_LATENCY; s++) begin
        tag_vld_q[s]  <= tag_vld_q[s-1];
        tag_port_q[s] <= tag_port_q[s-1];
      end
    end
  end

  assign viol_hit  = chk_violation & tag_vld_q[CHK_LATENCY-1];
  assign viol_port = tag_port_q[CHK_LATENCY-1];

  // Verdicts for a quarantined port fall through untouched, so stale words never re-alert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alert      <= 1'b0;
      alert_port <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i]   <= ST_ACTIVE;
        strikes_q[i] <= '0;
`ifndef AEGIS_STICKY_QUARANTINE_EN
        timer_q[i]   <= '0;
`endif
      end
    end else begin
      alert <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        case (state_q[i])
          ST_ACTIVE: begin
            if (viol_hit && viol_port == PW'(i)) begin
              if (strikes_q[i] == STRIKE_LAST) begin
                strikes_q[i] <= '0;
                state_q[i]   <= ST_QUARANTINE;
`ifndef AEGIS_STICKY_QUARANTINE_EN
                timer_q[i]   <= TW'(QUAR_CYCLES);
`endif
                alert        <= 1'b1;
                alert_port   <= PW'(i);
              end else begin
                strikes_q[i] <= strikes_q[i] + SW'(1);
              end
            end
          end
          ST_QUARANTINE: begin
`ifdef AEGIS_STICKY_QUARANTINE_EN
            if (clr_quarantine[i]) state_q[i] <= ST_ACTIVE;
`else
            if (timer_q[i] == TW'(1)) begin
              state_q[i] <= ST_ACTIVE;
              timer_q[i] <= '0;
            end else begin
              timer_q[i] <= timer_q[i] - TW'(1);
            end
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_checker_arbiter.sv
// Directed bench for checker_arbiter with a per-cycle scoreboard of issued words and quarantine state.
module tb_checker_arbiter;
  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int SL  = 3;
  localparam int QC  = 64;

  typedef struct {
    int          port;
    logic [31:0] dat;
  } ent_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           chk_valid;
  logic [31:0]    chk_data;
  logic [1:0]     chk_port;
  logic           chk_violation = 1'b0;
  logic [N-1:0]   quarantine;
  logic           alert;
  logic [1:0]     alert_port;
`ifdef AEGIS_STICKY_QUARANTINE_EN
  logic [N-1:0]   drv_clr = '0;
`endif

  checker_arbiter #(.NUM_PORTS(N), .CHK_LATENCY(LAT), .STRIKE_LIMIT(SL), .QUAR_CYCLES(QC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .chk_valid     (chk_valid),
    .chk_data      (chk_data),
    .chk_port      (chk_port),
    .chk_violation (chk_violation),
`ifdef AEGIS_STICKY_QUARANTINE_EN
    .clr_quarantine(drv_clr),
`endif
    .quarantine    (quarantine),
    .alert         (alert),
    .alert_port    (alert_port)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0, n_err = 0;
  int     cyc = 0;
  bit     viol_at [0:4095];
  bit     tagv    [0:4095];
  int     tagp    [0:4095];
  ent_t   sbq[$];
  int     m_ptr, m_aport;
  bit     m_alert;
  bit     m_quar [N];
  int     m_str  [N];
  int     m_tmr  [N];
  int     seq    [N];
  logic [N-1:0] drv_valid = '0;
  int     flag_port = -1, flag_budget = 0;
  int     n_alert = 0;
  bit     q2_prev = 1'b0;
  int     q_rise = -1, q_fall = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] mq();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_quar[i];
    return v;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_aport = 0; m_alert = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_quar[i] = 1'b0; m_str[i] = 0; m_tmr[i] = 0;
    end
    sbq.delete();
  endtask

  task automatic tick();
    ent_t         e;
    bit           pv, vhit;
    int           pp, w, p, vport;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    // registered outputs from the edge that opened this cycle
    pv = 1'b0; pp = 0; e.port = 0; e.dat = '0;
    if (sbq.size() > 0) begin e = sbq.pop_front(); pv = 1'b1; pp = e.port; end
    check("chk_valid", chk_valid, pv);
    if (pv) begin
      check("chk_port", chk_port, pp);
      check("chk_data", chk_data, e.dat);
    end
    check("quarantine", quarantine, mq());
    check("alert", alert, m_alert);
    check("alert_port", alert_port, m_aport);
    if (alert === 1'b1) n_alert++;
    if (quarantine[2] && !q2_prev) q_rise = cyc;
    if (!quarantine[2] && q2_prev) q_fall = cyc;
    q2_prev = quarantine[2];
    tagv[cyc] = pv && rst_n;
    tagp[cyc] = pp;
    if (pv && pp == flag_port && flag_budget > 0) begin
      viol_at[cyc+LAT] = 1'b1;
      flag_budget--;
    end
    // drive this cycle's inputs
    chk_violation = viol_at[cyc];
    req_valid = rst_n ? drv_valid : '0;
    for (int i = 0; i < N; i++) req_data[32*i +: 32] = {8'(i), 24'(seq[i])};
    #1;
    w = -1; exp_rdy = '0;
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (w < 0 && req_valid[p] && !m_quar[p]) w = p;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    if (w >= 0) begin
      sbq.push_back('{port: w, dat: req_data[32*w +: 32]});
      m_ptr = (w + 1) % N;
      seq[w]++;
    end
    // state after the closing edge
    if (rst_n) begin
      vhit  = chk_violation && cyc >= LAT && tagv[cyc-LAT];
      vport = vhit ? tagp[cyc-LAT] : -1;
      m_alert = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_quar[i]) begin
`ifdef AEGIS_STICKY_QUARANTINE_EN
          if (drv_clr[i]) m_quar[i] = 1'b0;
`else
          if (m_tmr[i] == 1) begin m_quar[i] = 1'b0; m_tmr[i] = 0; end
          else m_tmr[i]--;
`endif
        end else if (vhit && vport == i) begin
          m_str[i]++;
          if (m_str[i] == SL) begin
            m_str[i] = 0; m_tmr[i] = QC; m_quar[i] = 1'b1;
            m_alert = 1'b1; m_aport = i;
          end
        end
      end
    end
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < N; i++) seq[i] = 0;
    m_reset();
    // reset and round-robin fairness
    repeat (3) tick();
    rst_n = 1'b1;
    drv_valid = '1;
    repeat (12) tick();

    // two strikes on port 2 while sharing, then a third that quarantines it with words in flight
    flag_port = 2; flag_budget = 2;
    repeat (12) tick();
    drv_valid = 4'b0100; flag_budget = 4;
    repeat (8) tick();
    viol_at[cyc+1] = 1'b1;
    repeat (4) tick();
    check("alert_count_1", n_alert, 1);
    check("alert_port_2", alert_port, 2);
    check("quar_vec", quarantine, 4'b0100);
    drv_valid = '1;
    repeat (8) tick();

`ifdef AEGIS_STICKY_QUARANTINE_EN
    repeat (70) tick();
    check("sticky_hold", quarantine[2], 1'b1);
    drv_clr = 4'b0100;
    tick();
    drv_clr = '0;
    tick();
    check("sticky_clear", quarantine[2], 1'b0);
`else
    for (int g = 0; g < 100 && q_fall < 0; g++) tick();
    check("quar_length", q_fall - q_rise, QC);
`endif

    // strikes restart from zero after release
    flag_budget = 2;
    repeat (12) tick();
    check("no_realert", n_alert, 1);
    flag_budget = 1;
    repeat (10) tick();
    check("alert_count_2", n_alert, 2);

    // async reset in the middle of quarantine
    repeat (3) tick();
    #3 rst_n = 1'b0;
    #1;
    check("rst_chk_valid", chk_valid, 1'b0);
    check("rst_quarantine", quarantine, '0);
    check("rst_alert", alert, 1'b0);
    check("rst_alert_port", alert_port, 0);
    m_reset();
    flag_budget = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    viol_at[cyc+2] = 1'b1;
    flag_budget = 3;
    repeat (20) tick();
    check("alert_count_3", n_alert, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
